// File: rtl/shift_left_pipe_32b_if.sv
// Handshake bus of the pipelined left shifter: operand/shift-amount in, result out.
interface shift_left_pipe_32b_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_i;
  logic [SHW-1:0]   shamt_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_o;

  modport slave (
    input  in_valid_i, in_i, shamt_i, out_ready_i,
    output in_ready_o, out_valid_o, out_o
  );

  modport master (
    output in_valid_i, in_i, shamt_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_o
  );
endinterface

// File: rtl/shift_left_pipe_32b.sv
// Logarithmic left shifter, one stage per shift-amount bit, with valid/ready
// backpressure, flush and synchronous reset.
module shift_left_pipe_32b #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  shift_left_pipe_32b_if.slave  bus,
  output logic                  busy_o
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0]   valid_q, valid_d;
  logic [SHW-1:0]   adv_c;
  logic             in_ready_c;
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    logic carry;
    adv_c = '0;
    carry = bus.out_ready_i;
    for (int k = SHW - 1; k >= 0; k--) begin
      carry    = carry | ~valid_q[k];
      adv_c[k] = carry;
    end
  end

  assign in_ready_c     = adv_c[0] & ~flush_i;
  assign bus.in_ready_o = in_ready_c;

  // Invalid stages are loaded with zero so the output reads 0 when not valid.
  always_comb begin
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic [SHW-1:0]   src_shamt;
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    for (int k = 0; k < SHW; k++) begin
      if (k == 0) begin
        src_valid = bus.in_valid_i & in_ready_c;
        src_data  = bus.in_i;
        src_shamt = bus.shamt_i;
      end else begin
        src_valid = valid_q[k-1];
        src_data  = data_q[k-1];
        src_shamt = shamt_q[k-1];
      end
      if (flush_i) begin
        valid_d[k] = 1'b0;
        data_d[k]  = '0;
        shamt_d[k] = '0;
      end else if (adv_c[k]) begin
        valid_d[k] = src_valid;
        if (src_valid) begin
          data_d[k]  = src_shamt[0] ? (src_data << (2 ** k)) : src_data;
          shamt_d[k] = src_shamt >> 1;
        end else begin
          data_d[k]  = '0;
          shamt_d[k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
      end
    end
  end

  assign bus.out_valid_o = valid_q[SHW-1];
  assign bus.out_o       = data_q[SHW-1];
  assign busy_o          = |valid_q;
endmodule

// File: tb/tb_shift_left_pipe_32b.sv
// Self-checking bench for shift_left_pipe_32b: vector table, latency, stall,
// random streams against a queue reference model, flush and reset.
module tb_shift_left_pipe_32b;
  localparam int unsigned STAGES = 5;

  logic clk;
  logic rst_i;
  logic flush_i;
  logic busy_o;

  shift_left_pipe_32b_if #(.WIDTH(32)) bus ();

  shift_left_pipe_32b #(.WIDTH(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .bus     (bus),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          last_in_cyc = 0;
  int          last_out_cyc = 0;
  int          n_in = 0;
  int          n_out = 0;
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_out = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: multiply by 2**b, keep the low 32 bits.
  function automatic logic [31:0] ref_shl(input logic [31:0] a, input logic [4:0] b);
    logic [63:0] p;
    p = 64'(a) * (64'd1 << b);
    return p[31:0];
  endfunction

  // One clock cycle: drive just after the falling edge, evaluate the
  // handshakes 1ns later, then advance to the next falling edge.
  task automatic drive(input logic iv, input logic [31:0] a, input logic [4:0] b,
                       input logic [31:0] exp, input logic ordy, input logic fl,
                       input logic rs);
    logic exp_rdy;
    logic [31:0] front;
    bus.in_valid_i  = iv;
    bus.in_i        = a;
    bus.shamt_i     = b;
    bus.out_ready_i = ordy;
    flush_i         = fl;
    rst_i           = rs;
    #1;
    if (!rs) begin
      exp_rdy = !fl && ((exp_q.size() < STAGES) || ordy);
      check("in_ready", 32'(bus.in_ready_o), 32'(exp_rdy));
      check("busy", 32'(busy_o), 32'(exp_q.size() != 0));
      if (!bus.out_valid_o) check("out_zero_when_idle", bus.out_o, 32'h0);
      if (stalled_prev) begin
        check("stall_valid", 32'(bus.out_valid_o), 32'h1);
        check("stall_data", bus.out_o, prev_out);
      end
      if (bus.out_valid_o && ordy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'h1, 32'h0);
        end else begin
          front = exp_q.pop_front();
          check("result", bus.out_o, front);
        end
        last_out_cyc = cyc;
        n_out++;
      end
      if (iv && bus.in_ready_o) begin
        exp_q.push_back(exp);
        last_in_cyc = cyc;
        n_in++;
      end
      stalled_prev = bus.out_valid_o && !ordy && !fl;
      prev_out     = bus.out_o;
    end else begin
      stalled_prev = 1'b0;
    end
    if (fl || rs) exp_q.delete();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic idle_state_checks(input string tag);
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    flush_i         = 1'b0;
    rst_i           = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'h0);
    check({tag, "_out"}, bus.out_o, 32'h0);
    check({tag, "_busy"}, 32'(busy_o), 32'h0);
    check({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'h1);
  endtask

  task automatic rand_op(input logic iv, input logic ordy);
    logic [31:0] a;
    logic [4:0]  b;
    a = $urandom();
    b = 5'($urandom_range(0, 31));
    drive(iv, a, b, ref_shl(a, b), ordy, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   o0, i0;
    vecs[0] = '{32'h8000_0001, 5'd1,  32'h0000_0002};
    vecs[1] = '{32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    vecs[2] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[3] = '{32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[4] = '{32'h1234_5678, 5'd4,  32'h2345_6780};
    vecs[5] = '{32'h0000_0000, 5'd17, 32'h0000_0000};
    vecs[6] = '{32'hA5A5_A5A5, 5'd8,  32'hA5A5_A500};
    vecs[7] = '{32'hFFFF_FFFE, 5'd30, 32'h8000_0000};

    bus.in_valid_i  = 1'b0;
    bus.in_i        = '0;
    bus.shamt_i     = '0;
    bus.out_ready_i = 1'b1;
    flush_i         = 1'b0;
    rst_i           = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle_state_checks("reset");

    // Single operation latency.
    drive(1'b1, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    drain();
    check("latency", 32'(last_out_cyc - last_in_cyc), 32'(STAGES));

    // Vector table streamed back to back.
    foreach (vecs[i]) drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b1, 1'b0, 1'b0);
    drain();

    // Stall with a full pipeline.
    drive(1'b1, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) rand_op(1'b1, 1'b0);
    bus.in_valid_i = 1'b1;
    #1;
    check("stall_full_in_ready", 32'(bus.in_ready_o), 32'h0);
    check("stall_head", bus.out_o, 32'hFFFF_FFFF);
    drain();

    // Back-to-back random stream.
    o0 = n_out;
    for (int i = 0; i < 1000; i++) rand_op(1'b1, 1'b1);
    check("b2b_outputs", 32'(n_out - o0), 32'(1000 - STAGES));
    drain();
    check("b2b_total", 32'(n_out - o0), 32'd1000);

    // Random backpressure.
    o0 = n_out;
    i0 = n_in;
    for (int i = 0; i < 400; i++) rand_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    check("bp_balance", 32'(n_out - o0), 32'(n_in - i0));

    // Flush with three operations in flight and an input offered alongside.
    for (int i = 0; i < 3; i++) rand_op(1'b1, 1'b1);
    drive(1'b1, 32'h1, 5'd1, 32'h2, 1'b1, 1'b1, 1'b0);
    idle_state_checks("flush");
    o0 = n_out;
    idle(10);
    check("flush_no_results", 32'(n_out - o0), 32'h0);

    // Reset with four operations in flight.
    for (int i = 0; i < 4; i++) rand_op(1'b1, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
    idle_state_checks("midreset");
    o0 = n_out;
    idle(10);
    check("reset_no_results", 32'(n_out - o0), 32'h0);
    drive(1'b1, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    drain();
    check("post_reset_latency", 32'(last_out_cyc - last_in_cyc), 32'(STAGES));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_left_pipe_32b.md
SHIFT_LEFT_PIPE_32B -- requirements
Module: shift_left_pipe_32b

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data width; legal values are powers of two, 2 to 64.
REQ-002 The block SHALL derive local constant SHW = clog2(WIDTH), default 5, shift-amount width and stage count.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discard all in-flight operations.
REQ-006 The block SHALL have port in_valid_i, input, 1 bit: in_i and shamt_i are valid.
REQ-007 The block SHALL have port in_ready_o, output, 1 bit: the block accepts input this cycle.
REQ-008 The block SHALL have port in_i, input, WIDTH bits: operand to shift.
REQ-009 The block SHALL have port shamt_i, input, SHW bits: unsigned left-shift amount.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: out_o holds a result.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port out_o, output, WIDTH bits: in_i << shamt_i, zero-filled, truncated to WIDTH.
REQ-013 The block SHALL have port busy_o, output, 1 bit: at least one stage holds a valid operation.

Function
REQ-014 The block SHALL be a pipeline of SHW stages; stage k (k = 0..SHW-1) shifts left by 2^k when shamt bit k = 1 and passes data unchanged otherwise.
REQ-015 Each stage SHALL register data, the remaining shamt bits, and a valid bit; out_o and out_valid_o SHALL come directly from the last stage's registers.
REQ-016 An input transfer SHALL occur when in_valid_i and in_ready_o are both 1; an output transfer SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-017 Latency SHALL be exactly SHW cycles from input transfer to out_valid_o = 1 when there is no backpressure (5 for WIDTH = 32).
REQ-018 Throughput SHALL be one operation per cycle when out_ready_i is held at 1.
REQ-019 Stage k SHALL advance when it is empty or stage k+1 advances; the last stage SHALL advance when it is empty or an output transfer occurs.
REQ-020 in_ready_o SHALL equal the stage-0 advance condition; it is combinational from out_ready_i through the stage valid bits, with no combinational path from in_valid_i.
REQ-021 While out_valid_o = 1 and out_ready_i = 0, out_o SHALL hold stable; no operation SHALL be lost, duplicated or reordered.
REQ-022 With shamt = 0, the result SHALL equal the operand; with shamt = WIDTH-1, the result SHALL be operand bit 0 in the MSB and zeros elsewhere.
REQ-023 flush_i = 1 SHALL clear all stage valid bits on that edge and force in_ready_o = 0 that cycle; an input offered in the same cycle SHALL be dropped.
REQ-024 A pending output transfer in the flush cycle SHALL still complete; no further results from pre-flush operations SHALL appear.
REQ-025 busy_o SHALL be the OR of all stage valid bits.
REQ-026 Data registers of invalid stages are don't-care, but out_o SHALL be 0 whenever out_valid_o = 0.

Reset
REQ-027 When rst_i = 1 at a clock edge, all valid bits SHALL be cleared and all data and shamt registers SHALL be set to 0; reset has priority over flush_i and handshakes.
REQ-028 During reset and on the first cycle after it, the block SHALL drive out_valid_o = 0, out_o = 0 and busy_o = 0, with in_ready_o = 1 once rst_i = 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight operations; no result of any of them SHALL ever appear.

Verification
REQ-030 The bench SHALL apply in_i = 0x8000_0001, shamt_i = 1 with out_ready_i = 1; it SHALL observe out_o = 0x0000_0002 with out_valid_o = 1 exactly 5 cycles after the transfer.
REQ-031 The bench SHALL stream 1000 back-to-back random pairs with out_ready_i = 1; it SHALL observe one result per cycle, in order, each equal to (a << b) mod 2^32.
REQ-032 The bench SHALL apply in_i = 0xFFFF_FFFF with shamt 0 then 31 while holding out_ready_i = 0 for 10 cycles; it SHALL observe results 0xFFFF_FFFF then 0x8000_0000, stable while stalled, with in_ready_o = 0 once all 5 stages are full.
REQ-033 The bench SHALL apply a random toggle on out_ready_i at 50 % with random inputs; every accepted input SHALL produce exactly one matching output, with no loss or duplication.
REQ-034 The bench SHALL inject 3 operations, then flush_i = 1 for one cycle; it SHALL observe busy_o = 0 next cycle and none of the 3 results emerging.
REQ-035 The bench SHALL assert rst_i for one cycle with 4 operations in flight; it SHALL observe out_valid_o = 0, out_o = 0 and busy_o = 0, then normal operation on the next input.
